// File: rtl/mire_writer.sv
// Wishbone master that fills the framebuffer with a grid test pattern ("mire").
// Optional feature macro: MIRE_CONTINUOUS_EN (rewrite the frame forever instead of stopping once).
module mire_writer #(
  parameter int          HDISP        = 800,
  parameter int          VDISP        = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          GRID         = 16,
  parameter int          BURST_LEN    = 64,
  parameter int          PAUSE_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  output logic        done,
  output logic [7:0]  frame_cnt
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, PAUSE, DONE} state_t;

  state_t        state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] beat_q;
  logic [PW-1:0] pause_q;
  logic          cyc_q, stb_q, done_q;
  logic [31:0]   adr_q, dat_q;
  logic [7:0]    frame_q;
  logic          last_x, last_y, eof;

  function automatic logic [31:0] pix(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ((int'(x) % GRID == 0) || (int'(y) % GRID == 0)) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  // Raster position of the pixel that follows the one currently on the bus.
  always_comb begin
    last_x = (x_q == XW'(HDISP - 1));
    last_y = (y_q == YW'(VDISP - 1));
    eof    = last_x && last_y;
    x_d    = last_x ? '0 : x_q + XW'(1);
    y_d    = !last_x ? y_q : (last_y ? '0 : y_q + YW'(1));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      pause_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= BASE_ADDR;
      dat_q   <= 32'h0;
      frame_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= WRITE;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            dat_q   <= pix(x_q, y_q);
          end
        end
        WRITE: begin
          if (wshb_ack) begin
            x_q   <= x_d;
            y_q   <= y_d;
            dat_q <= pix(x_d, y_d);
            if (eof) begin
              adr_q   <= BASE_ADDR;
              frame_q <= frame_q + 8'd1;
              beat_q  <= '0;
              pause_q <= '0;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
`ifdef MIRE_CONTINUOUS_EN
              state_q <= PAUSE;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              adr_q <= adr_q + 32'd4;
              if (beat_q == BW'(BURST_LEN - 1)) begin
                beat_q  <= '0;
                pause_q <= '0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                state_q <= PAUSE;
              end else begin
                beat_q <= beat_q + BW'(1);
              end
            end
          end else if (wshb_err || wshb_rty) begin
            // Failed beat: keep the bus and re-issue the same address and data.
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
          end
        end
        PAUSE: begin
          if (pause_q == PW'(PAUSE_CYCLES - 1)) begin
            if (enable) begin
              state_q <= WRITE;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              dat_q   <= pix(x_q, y_q);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            pause_q <= pause_q + PW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wshb_cyc    = cyc_q;
  assign wshb_stb    = stb_q;
  assign wshb_we     = 1'b1;
  assign wshb_adr    = adr_q;
  assign wshb_dat_ms = dat_q;
  assign wshb_sel    = 4'hF;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign done        = done_q;
  assign frame_cnt   = frame_q;

endmodule

// File: doc/mire_writer.md
Name: mire_writer

Overview:
- Wishbone master test-pattern generator that fills the SDRAM framebuffer with a grid pattern ("mire").
- Sits directly upstream of the VGA reader: it writes the frame that the VGA block fetches from SDRAM.
- Runs in the system clock domain and shares the SDRAM slave with the VGA reader through an arbiter.
- Releases the bus periodically so the reader is not starved.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADDR, 32'h0, byte address of pixel (0,0).
- GRID, 16, grid pitch in pixels; power of two.
- BURST_LEN, 64, acked writes per bus tenure before release; at least 1.
- PAUSE_CYCLES, 4, idle cycles with cyc low between tenures; at least 1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset; synchronous, active-high.
- enable  in  1  run request, level-sensitive.
- wshb_cyc  out  1  Wishbone cycle.
- wshb_stb  out  1  Wishbone strobe.
- wshb_we  out  1  write enable; constant 1.
- wshb_adr  out  32  byte address.
- wshb_dat_ms  out  32  write data.
- wshb_sel  out  4  byte select; constant 4'hF.
- wshb_cti  out  3  constant 3'b000 (classic cycle).
- wshb_bte  out  2  constant 2'b00.
- wshb_ack  in  1  slave acknowledge.
- wshb_err  in  1  slave error.
- wshb_rty  in  1  slave retry.
- done  out  1  single-frame mode: frame completely written.
- frame_cnt  out  8  completed frames, wraps modulo 256.

Behaviour:
- Clock and reset: one clock (sys_clk); reset is synchronous and active-high (sys_rst).
- Outputs are registered.
- Reset values: cyc=0, stb=0, adr=BASE_ADDR, dat_ms=0, done=0, frame_cnt=0. Internal x=0, y=0, beat=0, state=IDLE.
- Pixel data: dat_ms = 32'h00FFFFFF if (x mod GRID==0) or (y mod GRID==0), else 32'h0.
- Address: adr = BASE_ADDR + 4*(y*HDISP + x). Computed incrementally by +4 per advance; no multiplier.
- State IDLE: cyc=stb=0. If enable is sampled high, go to WRITE. First stb appears 1 cycle after enable is sampled.
- State WRITE: cyc=stb=1.
  - adr and dat_ms are held stable while stb is high and ack is low (wait states of any length).
  - On ack, advance x. If x==HDISP-1: x=0 and y increments. If also y==VDISP-1: y=0, end of frame.
  - On ack, beat increments.
  - err or rty ends the transfer with no advance and no beat increment; the same adr/dat is re-issued next cycle with cyc held high.
- Leaving WRITE, on the acked beat:
  - End of frame: frame_cnt increments; go to DONE (single-frame mode) or PAUSE (continuous mode). beat=0.
  - Otherwise, if beat==BURST_LEN-1: go to PAUSE, beat=0.
- State PAUSE: cyc=stb=0 for exactly PAUSE_CYCLES cycles. Then go to WRITE if enable is high, else IDLE. enable is sampled only in IDLE and at the end of PAUSE; it never aborts an in-flight transfer or tenure.
- State DONE: cyc=stb=0, done=1. Stays here until reset.
- Only ack / err / rty are sampled, and only while stb is high. Simultaneous ack and err: ack wins.
- Reset mid-transfer: cyc and stb go to 0 on the reset edge, all counters clear, and generation restarts at BASE_ADDR.
- No combinational path from wshb_ack to any output.

Optional Feature:
- Macro: MIRE_CONTINUOUS_EN.
- Defined: after the last pixel, the FSM enters PAUSE and rewrites the frame from BASE_ADDR indefinitely. frame_cnt increments each frame; done stays 0.
- Undefined: exactly one frame is written, then the FSM enters DONE with done=1 and frame_cnt=1.

Test Plan:
- Common bench settings: HDISP=32, VDISP=8, GRID=16, BURST_LEN=64, PAUSE_CYCLES=4.
1. Reset held, enable=1 → cyc=stb=done=0, frame_cnt=0, adr=BASE_ADDR throughout.
2. Zero-wait slave, enable=1, macro undefined →
   - first write adr=0, dat=00FFFFFF;
   - (x=1,y=1) adr=0x84, dat=0;
   - (x=16,y=1) adr=0xC0, dat=00FFFFFF;
   - exactly 256 acks, then done=1, frame_cnt=1, cyc stays 0.
3. Same run → cyc falls after acks 64, 128, 192 for exactly 4 cycles each; 4 tenures total.
4. Slave with 3-cycle ack latency; err on the transfer at adr 0x28 → adr/dat stable during waits; adr 0x28 re-issued next cycle; final write count still 256.
5. sys_rst pulsed for 1 cycle after 100 acks → cyc=0 on the next edge; next first write adr=0; full frame completes.
6. MIRE_CONTINUOUS_EN defined → after adr 0x3FC is acked, the next write after PAUSE is adr 0; frame_cnt reaches 2 with done=0.
